// File: rtl/aes_host_loader.sv
// Host-side loader for the AES-128 core: byte-wide key/plaintext staging,
// one-shot load, busy handshake with timeout, and ciphertext capture.
module aes_host_loader #(
  parameter int TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en_i,
  input  logic [5:0]   wr_addr_i,
  input  logic [7:0]   wr_data_i,
  input  logic [5:0]   rd_addr_i,
  output logic [7:0]   rd_data_o,
  input  logic         go_i,
  output logic [127:0] key_o,
  output logic [127:0] text_o,
  output logic         load_o,
  input  logic         busy_i,
  input  logic [127:0] ct_i,
  output logic         active_o,
  output logic         done_o,
  output logic         timeout_o
);

  // state   | meaning
  // IDLE    | accepting host writes and go_i
  // LOAD    | load_o pulse, inputs frozen
  // WAIT_HI | waiting for core to raise busy_i
  // WAIT_LO | waiting for busy_i to fall, then capture ct_i
  typedef enum logic [1:0] {IDLE, LOAD, WAIT_HI, WAIT_LO} state_t;

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [127:0]    key_q, text_q, ct_q;
  logic            go_acc, capture, abort, wr_acc;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    go_acc  = 1'b0;
    capture = 1'b0;
    abort   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (go_i) begin
          go_acc  = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: state_d = WAIT_HI;
      WAIT_HI: begin
        if (busy_i) begin
          state_d = WAIT_LO;
        end else if (cnt_q == CNT_LAST) begin
          abort   = 1'b1;
          state_d = IDLE;
        end
      end
      WAIT_LO: begin
        // a falling busy_i in the last counted cycle still counts as success
        if (!busy_i) begin
          capture = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          abort   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign wr_acc   = wr_en_i && (state_q == IDLE) && !wr_addr_i[5];
  assign load_o   = (state_q == LOAD);
  assign active_o = (state_q != IDLE);
  assign key_o    = key_q;
  assign text_o   = text_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      key_q     <= '0;
      text_q    <= '0;
      ct_q      <= '0;
      rd_data_o <= '0;
      done_o    <= 1'b0;
      timeout_o <= 1'b0;
    end else begin
      done_o <= capture;

      if (go_acc)     timeout_o <= 1'b0;
      else if (abort) timeout_o <= 1'b1;

      if (state_q == LOAD)
        cnt_q <= '0;
      else if (state_q == WAIT_HI || state_q == WAIT_LO)
        cnt_q <= cnt_q + CW'(1);

      if (capture) ct_q <= ct_i;

      // big-endian: byte offset 0 is bits [127:120], so bit base = 8*(15-offset)
      if (wr_acc) begin
        if (!wr_addr_i[4]) key_q[{~wr_addr_i[3:0], 3'b000} +: 8]  <= wr_data_i;
        else               text_q[{~wr_addr_i[3:0], 3'b000} +: 8] <= wr_data_i;
      end

      unique case (rd_addr_i[5:4])
        2'd0:    rd_data_o <= key_q[{~rd_addr_i[3:0], 3'b000} +: 8];
        2'd1:    rd_data_o <= text_q[{~rd_addr_i[3:0], 3'b000} +: 8];
        2'd2:    rd_data_o <= ct_q[{~rd_addr_i[3:0], 3'b000} +: 8];
        default: rd_data_o <= 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_host_loader.sv
// Directed bench for aes_host_loader: register map, FIPS-197 run, timeout,
// locking during an operation, write+go collision and mid-run reset.
module tb_aes_host_loader;

  logic         clk = 1'b0;
  logic         rst;
  logic         wr_en_i;
  logic [5:0]   wr_addr_i;
  logic [7:0]   wr_data_i;
  logic [5:0]   rd_addr_i;
  logic [7:0]   rd_data_o;
  logic         go_i;
  logic [127:0] key_o;
  logic [127:0] text_o;
  logic         load_o;
  logic         busy_i;
  logic [127:0] ct_i;
  logic         active_o;
  logic         done_o;
  logic         timeout_o;

  int checks   = 0;
  int failures = 0;
  int load_cnt = 0;
  int done_cnt = 0;

  localparam logic [127:0] FIPS_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_TEXT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  aes_host_loader #(.TIMEOUT(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (wr_en_i),
    .wr_addr_i (wr_addr_i),
    .wr_data_i (wr_data_i),
    .rd_addr_i (rd_addr_i),
    .rd_data_o (rd_data_o),
    .go_i      (go_i),
    .key_o     (key_o),
    .text_o    (text_o),
    .load_o    (load_o),
    .busy_i    (busy_i),
    .ct_i      (ct_i),
    .active_o  (active_o),
    .done_o    (done_o),
    .timeout_o (timeout_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst) begin
      if (load_o) load_cnt <= load_cnt + 1;
      if (done_o) done_cnt <= done_cnt + 1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic write_byte(input logic [5:0] a, input logic [7:0] d);
    wr_en_i = 1'b1; wr_addr_i = a; wr_data_i = d;
    tick();
    wr_en_i = 1'b0;
  endtask

  task automatic load_fips();
    logic [127:0] k, t;
    k = FIPS_KEY;
    t = FIPS_TEXT;
    for (int i = 0; i < 16; i++) write_byte(6'(i), k[8*(15-i) +: 8]);
    for (int i = 0; i < 16; i++) write_byte(6'(16 + i), t[8*(15-i) +: 8]);
    chk("key_after_writes", key_o, FIPS_KEY);
    chk("text_after_writes", text_o, FIPS_TEXT);
  endtask

  task automatic check_ct_bytes(input string tag, input logic [127:0] exp_ct);
    for (int i = 0; i < 16; i++) begin
      rd_addr_i = 6'(32 + i);
      tick();
      chk(tag, {120'd0, rd_data_o}, {120'd0, exp_ct[8*(15-i) +: 8]});
    end
  endtask

  // go_i for one cycle; returns in the LOAD cycle
  task automatic start_go();
    go_i = 1'b1;
    tick();
    go_i = 1'b0;
  endtask

  // from the LOAD cycle: busy high for n cycles, then falls with ct presented;
  // returns in the cycle where done_o should be high
  task automatic finish_busy(input int n, input logic [127:0] ct);
    tick();
    busy_i = 1'b1;
    repeat (n) tick();
    busy_i = 1'b0;
    ct_i   = ct;
    tick();
    ct_i   = '0;
  endtask

  initial begin
    int l0, d0;
    rst = 1'b1; wr_en_i = 1'b0; wr_addr_i = '0; wr_data_i = '0;
    rd_addr_i = '0; go_i = 1'b0; busy_i = 1'b0; ct_i = '0;
    repeat (3) tick();
    rst = 1'b0;

    // reset state
    chk("rst_rd_data", {120'd0, rd_data_o}, 128'd0);
    chk("rst_load", {127'd0, load_o}, 128'd0);
    chk("rst_done", {127'd0, done_o}, 128'd0);
    chk("rst_timeout", {127'd0, timeout_o}, 128'd0);
    chk("rst_active", {127'd0, active_o}, 128'd0);
    chk("rst_key", key_o, 128'd0);
    chk("rst_text", text_o, 128'd0);

    for (int a = 0; a < 64; a++) begin
      rd_addr_i = 6'(a);
      tick();
      chk("rst_map_read", {120'd0, rd_data_o}, 128'd0);
    end

    // write then read back with one-cycle latency
    rd_addr_i = 6'h05;
    write_byte(6'h05, 8'ha5);
    chk("readback_same_cycle_old", {120'd0, rd_data_o}, 128'd0);
    tick();
    chk("readback_a5", {120'd0, rd_data_o}, 128'ha5);
    chk("key_87_80", {120'd0, key_o[87:80]}, 128'ha5);

    // FIPS-197 run
    load_fips();
    l0 = load_cnt; d0 = done_cnt;
    start_go();
    chk("fips_load_pulse", {127'd0, load_o}, 128'd1);
    chk("fips_active_load", {127'd0, active_o}, 128'd1);
    chk("fips_text_at_load", text_o, FIPS_TEXT);
    finish_busy(10, FIPS_CT);
    chk("fips_done", {127'd0, done_o}, 128'd1);
    chk("fips_idle_at_done", {127'd0, active_o}, 128'd0);
    tick();
    chk("fips_done_single", {127'd0, done_o}, 128'd0);
    chk("fips_load_count", 128'(load_cnt - l0), 128'd1);
    chk("fips_done_count", 128'(done_cnt - d0), 128'd1);
    check_ct_bytes("fips_ct_byte", FIPS_CT);

    // busy never rises: abort 64 cycles after the LOAD cycle
    d0 = done_cnt;
    ct_i = 128'hdeadbeef_deadbeef_deadbeef_deadbeef;
    start_go();
    chk("to_load", {127'd0, load_o}, 128'd1);
    tick();
    repeat (63) tick();
    chk("to_not_yet", {127'd0, timeout_o}, 128'd0);
    chk("to_still_active", {127'd0, active_o}, 128'd1);
    tick();
    chk("to_set", {127'd0, timeout_o}, 128'd1);
    chk("to_idle", {127'd0, active_o}, 128'd0);
    repeat (3) tick();
    chk("to_sticky", {127'd0, timeout_o}, 128'd1);
    chk("to_no_done", 128'(done_cnt - d0), 128'd0);
    ct_i = '0;
    check_ct_bytes("to_ct_unchanged", FIPS_CT);
    start_go();
    chk("to_cleared_by_go", {127'd0, timeout_o}, 128'd0);
    finish_busy(1, FIPS_CT);
    chk("to_rerun_done", {127'd0, done_o}, 128'd1);
    tick();

    // locking: write and go while in WAIT_LO are dropped
    l0 = load_cnt; d0 = done_cnt;
    start_go();
    tick();
    busy_i = 1'b1;
    tick();
    wr_en_i = 1'b1; wr_addr_i = 6'h00; wr_data_i = 8'hee; go_i = 1'b1;
    tick();
    wr_en_i = 1'b0; go_i = 1'b0;
    tick();
    chk("lock_key", key_o, FIPS_KEY);
    chk("lock_no_load", {127'd0, load_o}, 128'd0);
    chk("lock_active", {127'd0, active_o}, 128'd1);
    busy_i = 1'b0; ct_i = FIPS_CT;
    tick();
    ct_i = '0;
    chk("lock_done", {127'd0, done_o}, 128'd1);
    // go in the done cycle is accepted; minimum-latency run follows
    go_i = 1'b1;
    tick();
    go_i = 1'b0;
    chk("go_in_done_cycle", {127'd0, load_o}, 128'd1);
    chk("lock_load_count", 128'(load_cnt - l0), 128'd1);
    chk("lock_done_count", 128'(done_cnt - d0), 128'd1);
    finish_busy(1, 128'h0f0e0d0c0b0a09080706050403020100);
    chk("min_latency_done", {127'd0, done_o}, 128'd1);
    tick();
    rd_addr_i = 6'h20;
    tick();
    chk("min_ct_byte0", {120'd0, rd_data_o}, 128'h0f);

    // ignored writes to ciphertext region and unmapped reads
    write_byte(6'h25, 8'h77);
    rd_addr_i = 6'h25;
    tick();
    chk("ct_write_ignored", {120'd0, rd_data_o}, 128'h0a);
    rd_addr_i = 6'h30;
    tick();
    chk("unmapped_read", {120'd0, rd_data_o}, 128'h00);

    // simultaneous write + go
    write_byte(6'h1f, 8'h3c);
    chk("text_lsb_pre", {120'd0, text_o[7:0]}, 128'h3c);
    wr_en_i = 1'b1; wr_addr_i = 6'h1f; wr_data_i = 8'hff; go_i = 1'b1;
    tick();
    wr_en_i = 1'b0; go_i = 1'b0;
    chk("wrgo_load", {127'd0, load_o}, 128'd1);
    chk("wrgo_text_lsb", {120'd0, text_o[7:0]}, 128'hff);
    finish_busy(2, FIPS_CT);
    chk("wrgo_done", {127'd0, done_o}, 128'd1);
    tick();

    // reset in WAIT_HI
    d0 = done_cnt;
    start_go();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_active", {127'd0, active_o}, 128'd0);
    chk("rst_mid_load", {127'd0, load_o}, 128'd0);
    chk("rst_mid_done", {127'd0, done_o}, 128'd0);
    chk("rst_mid_timeout", {127'd0, timeout_o}, 128'd0);
    chk("rst_mid_key", key_o, 128'd0);
    chk("rst_mid_text", text_o, 128'd0);
    chk("rst_mid_rd", {120'd0, rd_data_o}, 128'd0);
    rd_addr_i = 6'h20;
    tick();
    chk("rst_mid_ct_cleared", {120'd0, rd_data_o}, 128'd0);
    chk("rst_mid_no_done", 128'(done_cnt - d0), 128'd0);

    load_fips();
    start_go();
    chk("post_rst_load", {127'd0, load_o}, 128'd1);
    finish_busy(10, FIPS_CT);
    chk("post_rst_done", {127'd0, done_o}, 128'd1);
    tick();
    check_ct_bytes("post_rst_ct_byte", FIPS_CT);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
